// File: rtl/morse_timed_decoder_if.sv
// -----------------------------------------------------------------------------
// morse_timed_decoder_if
// Groups the key/time-base inputs and the decoded symbol/code outputs of the
// Morse decoder into one bundle.
//   tick       : time-base enable pulse from the shared prescaler
//   b          : synchronised key level, 1 = key down
//   dot_out    : 1-cycle pulse, dot recognised
//   dash_out   : 1-cycle pulse, dash recognised
//   lg / wg    : 1-cycle pulses, letter gap / word gap
//   code       : packed symbols of the letter, bit0 = most recent, 1 = dash
//   code_len   : number of valid symbols in code
//   code_valid : 1-cycle pulse with lg, code/code_len/code_ovf are final
//   code_ovf   : letter had more symbols than fit in code
// Modports: slave = decoder side, master = key/time-base source and consumer.
// -----------------------------------------------------------------------------
interface morse_timed_decoder_if #(
    parameter int MAX_SYM = 5
);
    localparam int LEN_W = $clog2(MAX_SYM + 1);

    logic               tick;
    logic               b;
    logic               dot_out;
    logic               dash_out;
    logic               lg;
    logic               wg;
    logic [MAX_SYM-1:0] code;
    logic [LEN_W-1:0]   code_len;
    logic               code_valid;
    logic               code_ovf;

    modport slave (
        input  tick, b,
        output dot_out, dash_out, lg, wg, code, code_len, code_valid, code_ovf
    );

    modport master (
        output tick, b,
        input  dot_out, dash_out, lg, wg, code, code_len, code_valid, code_ovf
    );
endinterface

// File: rtl/morse_timed_decoder.sv
// -----------------------------------------------------------------------------
// morse_timed_decoder
// Classifies key marks as dot/dash by their length in time-base ticks, detects
// letter and word gaps from the following space, and packs the symbols of the
// current letter into a code word for the character lookup.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : morse_timed_decoder_if.slave (tick, b in; symbol/gap/code out)
// All outputs are registered: a pulse appears the cycle after the sampled event.
// -----------------------------------------------------------------------------
module morse_timed_decoder #(
    parameter int CNT_W      = 4,
    parameter int MIN_MARK   = 1,
    parameter int DASH_TICKS = 3,
    parameter int LG_TICKS   = 3,
    parameter int WG_TICKS   = 7,
    parameter int MAX_SYM    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    morse_timed_decoder_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_SYM + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_MARK);
    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
    // Gap events fire on the tick that would bring the count to the threshold.
    localparam logic [CNT_W-1:0] LG_END   = CNT_W'(LG_TICKS - 1);
    localparam logic [CNT_W-1:0] WG_END   = CNT_W'(WG_TICKS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SYM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAX_SYM-1:0] code_q, code_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               dot_q, dot_d;
    logic               dash_q, dash_d;
    logic               lg_q, lg_d;
    logic               wg_q, wg_d;
    logic               vld_q, vld_d;
    logic               sym;

    // Tick counter saturates instead of wrapping so very long marks stay dashes.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            lg_q    <= 1'b0;
            wg_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            dot_q   <= dot_d;
            dash_q  <= dash_d;
            lg_q    <= lg_d;
            wg_q    <= wg_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        dot_d   = 1'b0;
        dash_d  = 1'b0;
        lg_d    = 1'b0;
        wg_d    = 1'b0;
        vld_d   = 1'b0;
        sym     = 1'b0;

        // The finished letter is held for exactly the code_valid cycle, then
        // the accumulator is emptied. No mark can complete in that cycle.
        if (vld_q) begin
            code_d = '0;
            len_d  = '0;
            ovf_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.b) begin
                    state_d = S_MARK;
                end
            end

            S_MARK: begin
                if (bus.tick) begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (!bus.b) begin
                    state_d = S_SPACE;
                    // Marks shorter than MIN_MARK ticks are glitches and leave
                    // the accumulator untouched.
                    if (cnt_q >= MIN_C) begin
                        sym    = (cnt_q >= DASH_C);
                        dot_d  = ~sym;
                        dash_d = sym;
                        if (len_q == LEN_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            code_d = {code_q[MAX_SYM-2:0], sym};
                            len_d  = len_q + 1'b1;
                        end
                    end
                end
            end

            S_SPACE: begin
                if (bus.tick) begin
                    cnt_d = sat_inc(cnt_q);
                end
                // A new mark pre-empts any gap decision in the same cycle.
                if (bus.b) begin
                    state_d = S_MARK;
                end else if (bus.tick) begin
                    if (cnt_q == WG_END) begin
                        wg_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_q == LG_END && len_q != '0) begin
                        lg_d  = 1'b1;
                        vld_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state entry restarts the measurement.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign bus.dot_out    = dot_q;
    assign bus.dash_out   = dash_q;
    assign bus.lg         = lg_q;
    assign bus.wg         = wg_q;
    assign bus.code       = code_q;
    assign bus.code_len   = len_q;
    assign bus.code_valid = vld_q;
    assign bus.code_ovf   = ovf_q;

endmodule

// File: tb/tb_morse_timed_decoder.sv
module tb_morse_timed_decoder;
    logic clk;
    logic reset_n;

    morse_timed_decoder_if #(.MAX_SYM(5)) bus ();

    morse_timed_decoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int phase;
    int n_dot, n_dash, n_lg, n_wg, n_vld, n_viol;
    logic [4:0] cap_code;
    logic [2:0] cap_len;
    logic       cap_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; tick every 4th cycle.
    task automatic clk1(input logic bv);
        @(negedge clk);
        bus.b    = bv;
        bus.tick = (phase == 3);
        phase    = (phase + 1) % 4;
    endtask

    // Hold key level until n ticks have been applied (ends on a tick cycle).
    task automatic hold(input logic bv, input int n);
        int t;
        t = 0;
        while (t < n) begin
            clk1(bv);
            if (bus.tick) t++;
        end
    endtask

    task automatic settle();
        clk1(bus.b);
        clk1(bus.b);
    endtask

    task automatic clr_cnt();
        n_dot = 0; n_dash = 0; n_lg = 0; n_wg = 0; n_vld = 0;
        cap_code = 5'h1f; cap_len = 3'h7; cap_ovf = 1'bx;
    endtask

    // Pulse monitor, sampled on the falling edge.
    initial begin
        n_viol = 0;
        forever begin
            @(negedge clk);
            if (bus.dot_out)  n_dot++;
            if (bus.dash_out) n_dash++;
            if (bus.lg)       n_lg++;
            if (bus.wg)       n_wg++;
            if (bus.code_valid) begin
                n_vld++;
                cap_code = bus.code;
                cap_len  = bus.code_len;
                cap_ovf  = bus.code_ovf;
            end
            if ((bus.dot_out && bus.dash_out) || (bus.lg && bus.wg) || (bus.lg != bus.code_valid))
                n_viol++;
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; phase = 0;
        bus.b = 1'b0; bus.tick = 1'b0;
        reset_n = 1'b0;
        clr_cnt();
        repeat (3) clk1(1'b0);
        check_val("rst_dot",  bus.dot_out,    0);
        check_val("rst_dash", bus.dash_out,   0);
        check_val("rst_lg",   bus.lg,         0);
        check_val("rst_wg",   bus.wg,         0);
        check_val("rst_code", bus.code,       0);
        check_val("rst_len",  bus.code_len,   0);
        check_val("rst_vld",  bus.code_valid, 0);
        check_val("rst_ovf",  bus.code_ovf,   0);
        reset_n = 1'b1;
        phase = 0;
        clk1(1'b0); clk1(1'b0); clk1(1'b0); clk1(1'b0);

        // 1: single dot, then letter gap and word gap
        clr_cnt();
        hold(1'b1, 2);
        hold(1'b0, 3);
        settle();
        check_val("t1_dot",  n_dot, 1);
        check_val("t1_dash", n_dash, 0);
        check_val("t1_vld",  n_vld, 1);
        check_val("t1_lg",   n_lg, 1);
        check_val("t1_code", cap_code, 5'b00000);
        check_val("t1_len",  cap_len, 1);
        check_val("t1_ovf",  cap_ovf, 0);
        check_val("t1_clr",  bus.code_len, 0);
        hold(1'b0, 4);
        settle();
        check_val("t1_wg", n_wg, 1);

        // 2: letter A
        clr_cnt();
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 3);
        settle();
        check_val("t2_dot",  n_dot, 1);
        check_val("t2_dash", n_dash, 1);
        check_val("t2_vld",  n_vld, 1);
        check_val("t2_code", cap_code, 5'b00001);
        check_val("t2_len",  cap_len, 2);
        check_val("t2_ovf",  cap_ovf, 0);
        hold(1'b0, 4);
        settle();

        // 3: six dots overflow a five-symbol letter
        clr_cnt();
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        hold(1'b0, 2);
        settle();
        check_val("t3_dot",  n_dot, 6);
        check_val("t3_vld",  n_vld, 1);
        check_val("t3_code", cap_code, 5'b00000);
        check_val("t3_len",  cap_len, 5);
        check_val("t3_ovf",  cap_ovf, 1);
        hold(1'b0, 4);
        settle();
        check_val("t3_ovf_clr", bus.code_ovf, 0);

        // 4: glitch without a tick, then an empty letter gap, then a dot
        clr_cnt();
        while (phase != 0) clk1(1'b0);
        clk1(1'b1);
        clk1(1'b1);
        hold(1'b0, 3);
        settle();
        check_val("t4_gl_dot",  n_dot, 0);
        check_val("t4_gl_dash", n_dash, 0);
        check_val("t4_gl_lg",   n_lg, 0);
        check_val("t4_gl_len",  bus.code_len, 0);
        hold(1'b1, 2);
        hold(1'b0, 3);
        settle();
        check_val("t4_dot",  n_dot, 1);
        check_val("t4_code", cap_code, 5'b00000);
        check_val("t4_len",  cap_len, 1);
        hold(1'b0, 4);
        settle();

        // 5a: dash, gap timing: lg at tick 3, wg at tick 7, then idle
        clr_cnt();
        hold(1'b1, 3);
        hold(1'b0, 2);
        settle();
        check_val("t5_lg_early", n_lg, 0);
        hold(1'b0, 1);
        settle();
        check_val("t5_lg",   n_lg, 1);
        check_val("t5_code", cap_code, 5'b00001);
        check_val("t5_len",  cap_len, 1);
        hold(1'b0, 3);
        settle();
        check_val("t5_wg_early", n_wg, 0);
        hold(1'b0, 1);
        settle();
        check_val("t5_wg",    n_wg, 1);
        check_val("t5_lg_rep", n_lg, 1);
        hold(1'b0, 8);
        check_val("t5_idle", n_wg, 1);

        // 5b: key goes down on the third gap tick -> no letter gap
        clr_cnt();
        hold(1'b1, 3);
        hold(1'b0, 2);
        clk1(1'b0); clk1(1'b0); clk1(1'b0);
        clk1(1'b1);
        hold(1'b1, 1);
        settle();
        check_val("t5b_nolg", n_lg, 0);
        hold(1'b0, 3);
        settle();
        check_val("t5b_lg",   n_lg, 1);
        check_val("t5b_dot",  n_dot, 1);
        check_val("t5b_dash", n_dash, 1);
        check_val("t5b_code", cap_code, 5'b00010);
        check_val("t5b_len",  cap_len, 2);
        hold(1'b0, 4);
        settle();

        // 6: reset in the middle of a dash
        clr_cnt();
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 2);
        check_val("t6_pre_len", bus.code_len, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_len",  bus.code_len, 0);
        check_val("t6_rst_code", bus.code, 0);
        check_val("t6_rst_dash", bus.dash_out, 0);
        clk1(1'b0); clk1(1'b0);
        reset_n = 1'b1;
        clr_cnt();
        hold(1'b0, 1);
        hold(1'b1, 2);
        hold(1'b0, 3);
        settle();
        check_val("t6_dash", n_dash, 0);
        check_val("t6_dot",  n_dot, 1);
        check_val("t6_code", cap_code, 5'b00000);
        check_val("t6_len",  cap_len, 1);
        check_val("t6_ovf",  cap_ovf, 0);

        check_val("pulse_rules", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
